// File: rtl/i2c_mem_arbiter.sv
// i2c_mem_arbiter: round-robin sharing of one I2C memory command port.
// Ports: clk, rst (async active-low); req/req_wr/req_addr/req_wdata in;
//   gnt, rsp_valid, rsp_rdata, rsp_err, busy, wd_sticky out;
//   m_wr/m_addr/m_din to memory; m_done/m_rdata from memory.
// The command only changes on an m_done edge, or on reset/watchdog abort.
// gnt and rsp_valid are combinational pulses in the m_done cycle.
module i2c_mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ*7-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              wd_sticky,
    output logic              m_wr,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_din,
    input  logic              m_done,
    input  logic [7:0]        m_rdata
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {SYNC, IDLE, BUSY} state_t;

    state_t         r_state;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  r_owner;
    logic [CW-1:0]  r_wd;

    logic           w_found;
    logic [PW-1:0]  w_win;
    logic [PW-1:0]  w_idx;
    logic           w_sel_wr;
    logic [6:0]     w_sel_addr;
    logic [7:0]     w_sel_din;
    logic           w_wd_hit;
    logic           w_own_rsp;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (PW'(k) == w_win) begin
                w_sel_wr   = req_wr[k];
                w_sel_addr = req_addr[k*7 +: 7];
                w_sel_din  = req_wdata[k*8 +: 8];
            end
        end
    end

    // m_done in the same cycle as the timeout overrides the abort.
    assign w_wd_hit  = !m_done && (r_wd == WD_LAST);
    assign w_own_rsp = rst && (r_state == BUSY) && (m_done || w_wd_hit);

    assign gnt       = (rst && m_done && w_found) ? (ONE << w_win) : '0;
    assign rsp_valid = w_own_rsp ? (ONE << r_owner) : '0;
    assign rsp_err   = w_own_rsp && !m_done;
    // While BUSY, m_wr still holds the owner's command.
    assign rsp_rdata = (w_own_rsp && m_done && !m_wr) ? m_rdata : 8'h00;
    assign busy      = (r_state == BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= SYNC;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_wd      <= '0;
            wd_sticky <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_din     <= '0;
        end else if (m_done) begin
            r_wd <= '0;
            if (w_found) begin
                r_state <= BUSY;
                r_owner <= w_win;
                r_ptr   <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
                m_wr    <= w_sel_wr;
                m_addr  <= w_sel_addr;
                m_din   <= w_sel_din;
            end else begin
                r_state <= IDLE;
                m_wr    <= 1'b0;
                m_addr  <= '0;
                m_din   <= '0;
            end
        end else if (r_wd == WD_LAST) begin
            r_wd      <= '0;
            wd_sticky <= 1'b1;
            r_state   <= SYNC;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_din     <= '0;
        end else begin
            r_wd <= r_wd + CW'(1);
        end
    end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Bench for i2c_mem_arbiter: memory model, transaction-level reference,
// directed table, corner-case sequences and a randomized phase.
module tb_i2c_mem_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_wr = '0;
    logic [N*7-1:0] req_addr = '0;
    logic [N*8-1:0] req_wdata = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_err, busy, wd_sticky, m_wr;
    logic [6:0]     m_addr;
    logic [7:0]     m_din;
    logic           m_done = 1'b0;
    logic [7:0]     m_rdata = '0;

    i2c_mem_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .wd_sticky(wd_sticky),
        .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din),
        .m_done(m_done), .m_rdata(m_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // requesters
    bit       rq_on[N];
    bit       rq_wait[N];
    bit       rq_wr[N];
    bit [6:0] rq_addr[N];
    bit [7:0] rq_wd[N];
    bit       rand_mode = 0;

    // reference: transaction-level view
    int       own;
    bit       own_wr;
    bit [6:0] own_addr;
    bit [7:0] own_wd;
    int       rr;
    int       quiet;
    bit       sticky;
    bit       cmd_wr;
    bit [6:0] cmd_addr;
    bit [7:0] cmd_din;
    bit [7:0] ref_mem[128];

    // memory model
    bit [7:0] mem[128];
    bit       mcur_wr = 0;
    bit [6:0] mcur_addr = 0;
    bit [7:0] mcur_din = 0;
    int       mcnt = 5;
    bit       stall = 0;

    // observed at the last negedge
    logic [N-1:0] o_gnt, o_rsp;
    logic [7:0]   o_rdata;
    logic         o_err, o_busy, o_done;
    logic [15:0]  o_cmd;

    typedef struct {
        int       who;
        bit       wr;
        bit [6:0] addr;
        bit [7:0] wd;
        bit [7:0] rd;
    } vec_t;
    vec_t tv[5];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        own = -1; rr = 0; quiet = 0; sticky = 0;
        cmd_wr = 0; cmd_addr = 0; cmd_din = 0;
        for (int i = 0; i < N; i++) begin
            rq_on[i] = 0;
            rq_wait[i] = 0;
        end
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        int win;
        bit fire;
        logic [N-1:0] e_gnt, e_rsp;
        logic [7:0] e_rd;
        bit e_err;
        if (mcnt > 0) mcnt--;
        m_done = (mcnt == 0) && !stall;
        m_rdata = (m_done && !mcur_wr) ? mem[mcur_addr] : 8'($urandom);
        for (int i = 0; i < N; i++) begin
            req[i] = rq_on[i];
            req_wr[i] = rq_wr[i];
            req_addr[i*7 +: 7] = rq_addr[i];
            req_wdata[i*8 +: 8] = rq_wd[i];
        end
        @(negedge clk);
        win = -1; fire = 0;
        e_gnt = '0; e_rsp = '0; e_rd = '0; e_err = 0;
        if (rst) begin
            if (m_done)
                for (int k = 0; k < N; k++) begin
                    int j = (rr + k) % N;
                    if (win < 0 && rq_on[j]) win = j;
                end
            fire = !m_done && (quiet == TO - 1);
            if (win >= 0) e_gnt = N'(1) << win;
            if (own >= 0 && (m_done || fire)) begin
                e_rsp = N'(1) << own;
                e_err = fire;
                if (m_done && !own_wr) e_rd = ref_mem[own_addr];
            end
        end
        chk("gnt", gnt, e_gnt);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", rsp_err, e_err);
        chk("busy", busy, own >= 0);
        chk("wd_sticky", wd_sticky, sticky);
        chk("m_wr", m_wr, cmd_wr);
        chk("m_addr", m_addr, cmd_addr);
        chk("m_din", m_din, cmd_din);
        o_gnt = gnt; o_rsp = rsp_valid; o_rdata = rsp_rdata;
        o_err = rsp_err; o_busy = busy; o_done = m_done;
        o_cmd = {m_wr, m_addr, m_din};
        @(posedge clk);
        if (m_done) begin
            if (mcur_wr) mem[mcur_addr] = mcur_din;
            mcnt = $urandom_range(3, 9);
        end
        if (rst) begin
            if (m_done) begin
                if (own >= 0) begin
                    if (own_wr) ref_mem[own_addr] = own_wd;
                    rq_wait[own] = 0;
                end
                if (win >= 0) begin
                    own = win;
                    own_wr = rq_wr[win];
                    own_addr = rq_addr[win];
                    own_wd = rq_wd[win];
                    rq_on[win] = 0;
                    rq_wait[win] = 1;
                    rr = (win + 1) % N;
                    cmd_wr = own_wr; cmd_addr = own_addr; cmd_din = own_wd;
                end else begin
                    own = -1;
                    cmd_wr = 0; cmd_addr = 0; cmd_din = 0;
                end
                quiet = 0;
            end else if (fire) begin
                if (own >= 0) rq_wait[own] = 0;
                own = -1;
                cmd_wr = 0; cmd_addr = 0; cmd_din = 0;
                sticky = 1;
                quiet = 0;
            end else begin
                quiet++;
            end
        end
        #1;
        if (m_done) begin
            mcur_wr = m_wr; mcur_addr = m_addr; mcur_din = m_din;
        end
        if (rand_mode)
            for (int i = 0; i < N; i++) begin
                if (!rq_on[i] && !rq_wait[i] && $urandom_range(0, 99) < 20) begin
                    rq_on[i] = 1;
                    rq_wr[i] = 1'($urandom);
                    rq_addr[i] = 7'($urandom_range(0, 7));
                    rq_wd[i] = 8'($urandom);
                end else if (rq_on[i] && $urandom_range(0, 99) < 2) begin
                    rq_on[i] = 0;
                end
            end
    endtask

    task automatic wait_gnt(int who, string nm);
        int t = 0;
        o_gnt = '0;
        while (t < 200) begin
            cycle();
            t++;
            if (o_gnt != 0) break;
        end
        chk(nm, o_gnt, N'(1) << who);
    endtask

    task automatic wait_rsp(int who, string nm, logic [7:0] rd,
                            bit err, int bound);
        int t = 0;
        o_rsp = '0;
        while (t < bound) begin
            cycle();
            t++;
            if (o_rsp != 0) break;
        end
        chk(nm, o_rsp, N'(1) << who);
        chk({nm, "_rdata"}, o_rdata, rd);
        chk({nm, "_err"}, o_err, err);
    endtask

    task automatic issue(int who, bit wr, bit [6:0] a, bit [7:0] d);
        rq_on[who] = 1; rq_wr[who] = wr; rq_addr[who] = a; rq_wd[who] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit       any_rsp, any_busy;
        logic [15:0] any_cmd;
        int       nd, t, order[5];
        logic [N-1:0] any3;

        tv[0] = '{0, 1'b1, 7'h15, 8'hA5, 8'h00};
        tv[1] = '{2, 1'b0, 7'h15, 8'h00, 8'hA5};
        tv[2] = '{1, 1'b1, 7'h7F, 8'h3C, 8'h00};
        tv[3] = '{3, 1'b0, 7'h7F, 8'h00, 8'h3C};
        tv[4] = '{0, 1'b0, 7'h15, 8'h00, 8'hA5};
        order = '{0, 1, 2, 3, 0};

        model_reset();
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sticky", wd_sticky, 0);
        chk("rst_cmd", {m_wr, m_addr, m_din}, 0);
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1;

        // directed table
        foreach (tv[k]) begin
            issue(tv[k].who, tv[k].wr, tv[k].addr, tv[k].wd);
            wait_gnt(tv[k].who, "tbl_gnt");
            chk("tbl_m_wr", m_wr, tv[k].wr);
            chk("tbl_m_addr", m_addr, tv[k].addr);
            chk("tbl_m_din", m_din, tv[k].wd);
            wait_rsp(tv[k].who, "tbl_rsp", tv[k].rd, 0, 200);
        end

        // idle padding for 5 memory transactions
        any_rsp = 0; any_busy = 0; any_cmd = '0; nd = 0; t = 0;
        while (nd < 5 && t < 200) begin
            cycle();
            t++;
            if (o_done) nd++;
            any_rsp |= (o_rsp != 0);
            any_busy |= o_busy;
            any_cmd |= o_cmd;
        end
        chk("idle_dones", nd, 5);
        chk("idle_rsp", any_rsp, 0);
        chk("idle_busy", any_busy, 0);
        chk("idle_cmd", any_cmd, 0);

        // reset between gnt[3] and its m_done
        issue(3, 0, 7'h15, 8'h00);
        wait_gnt(3, "rb_gnt3");
        cycle();
        rst = 0;
        model_reset();
        #1;
        chk("rb_gnt", gnt, 0);
        chk("rb_rsp", rsp_valid, 0);
        chk("rb_busy", busy, 0);
        chk("rb_cmd", {m_wr, m_addr, m_din}, 0);
        chk("rb_sticky", wd_sticky, 0);
        cycle();
        cycle();
        cycle();
        rst = 1;
        any3 = '0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            any3 |= o_rsp;
        end
        chk("rb_no_rsp3", any3[3], 0);

        // fairness with everyone requesting
        for (int i = 0; i < N; i++) issue(i, 0, 7'(i), 8'(i));
        for (int g = 0; g < 5; g++) begin
            wait_gnt(order[g], "fair_gnt");
            if (g > 0)
                chk("fair_rsp_with_gnt", o_rsp, N'(1) << order[g-1]);
            for (int i = 0; i < N; i++)
                if (!rq_on[i] && !rq_wait[i]) issue(i, 0, 7'(i), 8'(i));
        end
        for (int i = 0; i < N; i++) rq_on[i] = 0;
        for (int i = 0; i < 40; i++) cycle();
        chk("fair_drain_busy", busy, 0);

        // watchdog during a req1 grant
        issue(1, 0, 7'h7F, 8'h00);
        wait_gnt(1, "wd_gnt1");
        stall = 1;
        wait_rsp(1, "wd_rsp", 8'h00, 1, TO + 10);
        cycle();
        chk("wd_sticky_set", wd_sticky, 1);
        chk("wd_not_busy", busy, 0);
        stall = 0;
        issue(2, 0, 7'h7F, 8'h00);
        wait_gnt(2, "wd_resume_gnt");
        wait_rsp(2, "wd_resume_rsp", ref_mem[7'h7F], 0, 200);

        // randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 2000; i++) cycle();
        rand_mode = 0;
        for (int i = 0; i < N; i++) rq_on[i] = 0;
        for (int i = 0; i < 60; i++) cycle();
        chk("rand_drain_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
